scmp_bus_if: RTL and testbench
==============================

// Module: scmp_bus_if
// PURPOSE
//  Demultiplexes the SC/MP core's external bus (ADS_n/RD_n/WR_n, 12-bit addr, D_o) onto a
//  synchronous single-port memory interface and returns read data to the core's D_i.
//  At ADS it latches the 16-bit address {D_o[3:0],addr} and the cycle flags {H,D,I,R}=D_o[7:4].
//  It issues the memory read early, holds the returned byte and produces one write strobe per cycle.
//  Sits between scmp and the system RAM/ROM/IO fabric; scmp has no hold input, so memory must meet RD_LAT.
// PARAMETERS
//  RD_LAT    2        max clk cycles from mem_rd to mem_rvalid before the read counts as late
//  ROM_TOP   16'h0FFF writes to mem_addr <= ROM_TOP are suppressed (write-protected region)
//  IDLE_DATA 8'hFF    value driven on cpu_D_i when no valid read byte is held
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  cpu_addr    in   12  core address register (low 12 bits)
//  cpu_D_o     in   8   core data out: {H,D,I,R,A[15:12]} during ADS, write data during WR_n
//  cpu_ADS_n   in   1   core address strobe, active low
//  cpu_RD_n    in   1   core read strobe, active low
//  cpu_WR_n    in   1   core write strobe, active low
//  cpu_D_i     out  8   read data to core
//  mem_addr    out  16  latched memory address
//  mem_rd      out  1   one-cycle read request
//  mem_we      out  1   one-cycle write strobe
//  mem_wdata   out  8   write data, valid with mem_we
//  mem_rdata   in   8   read data, valid with mem_rvalid
//  mem_rvalid  in   1   read data valid, one pulse per mem_rd
//  cyc_flags   out  4   latched {H,D,I,R} of the current cycle
//  halt_p      out  1   one-cycle pulse when a cycle with H=1 is latched
//  late_err    out  1   sticky: core sampled read data before it arrived
//  wp_err      out  1   sticky: write to protected region attempted
// BEHAVIOUR
//  Reset: all outputs 0 except cpu_D_i=IDLE_DATA; state IDLE; drop_cnt=0; rdata_vld=0.
//  ADS: on every clk with cpu_ADS_n=0 (any state), the block:
//   - latches mem_addr={cpu_D_o[3:0],cpu_addr} and cyc_flags=cpu_D_o[7:4];
//   - clears rdata_vld; halt_p=1 next cycle if D_o[7]=1;
//   - if a read is outstanding (RD_PEND), increments drop_cnt (abort; that late rvalid is discarded).
//   ADS held low for k cycles acts once, on the first cycle (edge detected).
//  FSM states: IDLE, RD_PEND, RD_DONE, WR_WAIT.
//  IDLE/any + ADS edge, R=1: mem_rd=1 for 1 cycle (cycle after ADS edge) -> RD_PEND, lat_cnt=0.
//  IDLE/any + ADS edge, R=0: -> WR_WAIT.
//  RD_PEND: lat_cnt increments (saturating at RD_LAT+1).
//   mem_rvalid with drop_cnt!=0: decrement drop_cnt, discard byte, stay.
//   mem_rvalid with drop_cnt==0: rdata<=mem_rdata, rdata_vld=1 -> RD_DONE.
//  RD_DONE: hold rdata until the next ADS edge.
//  WR_WAIT: on the first clk with cpu_WR_n=0: mem_we=1 for 1 cycle, mem_wdata=cpu_D_o -> IDLE.
//   If mem_addr<=ROM_TOP, mem_we stays 0 and wp_err<=1.
//   WR_n held low for k cycles -> exactly one mem_we.
//   WR_n low outside WR_WAIT is ignored.
//  cpu_D_i is combinational: rdata when rdata_vld=1 and cpu_RD_n=0, else IDLE_DATA.
//  late_err<=1 when cpu_RD_n=0 and state==RD_PEND.
//  Cleared only by reset; late_err also sets if lat_cnt exceeds RD_LAT.
//  mem_rvalid in IDLE/WR_WAIT/RD_DONE: decrements drop_cnt if nonzero, else ignored.
//  drop_cnt is 2 bits and saturates at 3.
//  ADS and rvalid in the same cycle: the rvalid is processed against the pre-ADS drop_cnt/state first.
//  The ADS abort is applied afterwards.
//  Reset mid-cycle: all state returns to reset values immediately; no strobe is emitted after rst_n falls.
// TESTING
//  1. Read: ADS with D_o=8'h15, addr=12'h234 -> mem_rd 1 cycle, mem_addr=16'h5234, cyc_flags=4'h1.
//     mem_rvalid, mem_rdata=8'hA7 after 2 cycles, then RD_n=0 -> cpu_D_i=8'hA7, late_err=0.
//  2. Write: ADS with D_o=8'h02, addr=12'h100, then D_o=8'h3C with WR_n low 3 cycles
//     -> one mem_we, mem_addr=16'h2100, mem_wdata=8'h3C.
//  3. Write-protect: write to 16'h0800 -> mem_we never asserts, wp_err=1.
//  4. Abort: read ADS, new read ADS before rvalid; first rvalid(8'h11) dropped, second rvalid(8'h22)
//     -> cpu_D_i=8'h22 on RD_n.
//  5. Late/halt: RD_n low while RD_PEND -> late_err=1, cpu_D_i=8'hFF.
//     ADS with D_o=8'h80 -> halt_p single pulse.
//  6. Reset asserted in RD_PEND -> cpu_D_i=8'hFF, mem_rd/mem_we=0, flags 0.
//     A later rvalid with no pending read is ignored.

Source files
------------

// File: rtl/scmp_bus_if_if.sv
// Bus bundle between the SC/MP core side, the bridge and the memory fabric.
// The bridge uses the slave modport; the core/memory model side uses master.
interface scmp_bus_if_if;
  // core-side bus
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_D_o;
  logic        cpu_ADS_n;
  logic        cpu_RD_n;
  logic        cpu_WR_n;
  logic [7:0]  cpu_D_i;
  // memory-side bus
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  // cycle status
  logic [3:0]  cyc_flags;
  logic        halt_p;
  logic        late_err;
  logic        wp_err;

  modport slave (
    input  cpu_addr, cpu_D_o, cpu_ADS_n, cpu_RD_n, cpu_WR_n,
    input  mem_rdata, mem_rvalid,
    output cpu_D_i,
    output mem_addr, mem_rd, mem_we, mem_wdata,
    output cyc_flags, halt_p, late_err, wp_err
  );

  modport master (
    output cpu_addr, cpu_D_o, cpu_ADS_n, cpu_RD_n, cpu_WR_n,
    output mem_rdata, mem_rvalid,
    input  cpu_D_i,
    input  mem_addr, mem_rd, mem_we, mem_wdata,
    input  cyc_flags, halt_p, late_err, wp_err
  );
endinterface

// File: rtl/scmp_bus_if.sv
// SC/MP external bus to synchronous single-port memory bridge.
// Latches address and cycle flags on the ADS falling edge, issues the read
// early, holds the returned byte for the core and emits one write strobe per
// write cycle. Late read data and writes into the protected region are
// flagged with sticky error bits.
module scmp_bus_if #(
  parameter int unsigned RD_LAT    = 2,
  parameter logic [15:0] ROM_TOP   = 16'h0FFF,
  parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  scmp_bus_if_if.slave  bus
);

  localparam int LAT_W = $clog2(RD_LAT + 2);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LIM = LAT_W'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    RD_DONE = 2'd2,
    WR_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             ads_n_q, ads_n_d;
  logic [15:0]      addr_q, addr_d;
  logic [3:0]       flags_q, flags_d;
  logic             rd_q, rd_d;
  logic             we_q, we_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rdata_vld_q, rdata_vld_d;
  logic             halt_q, halt_d;
  logic             late_q, late_d;
  logic             wp_q, wp_d;
  logic [1:0]       drop_q, drop_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             ads_edge;

  function automatic logic [1:0] drop_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
    return (v >= LAT_MAX) ? LAT_MAX : v + 1'b1;
  endfunction

  // ADS acts only on its falling edge, so a long strobe starts one cycle
  assign ads_edge = !bus.cpu_ADS_n && ads_n_q;

  // Next-state and output logic; returned data is handled before an ADS abort
  always_comb begin
    state_d     = state_q;
    ads_n_d     = bus.cpu_ADS_n;
    addr_d      = addr_q;
    flags_d     = flags_q;
    rd_d        = 1'b0;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rdata_vld_d = rdata_vld_q;
    halt_d      = 1'b0;
    late_d      = late_q;
    wp_d        = wp_q;
    drop_d      = drop_q;
    lat_d       = lat_q;

    // A returning byte first retires an aborted read, else completes ours
    if (bus.mem_rvalid) begin
      if (drop_q != 2'd0) begin
        drop_d = drop_q - 2'd1;
      end else if (state_q == RD_PEND) begin
        rdata_d     = bus.mem_rdata;
        rdata_vld_d = 1'b1;
        state_d     = RD_DONE;
      end
    end

    case (state_q)
      RD_PEND: begin
        lat_d = lat_inc(lat_q);
        // core strobing read data that is not here yet, or memory too slow
        if (!bus.cpu_RD_n || (lat_q > LAT_LIM)) late_d = 1'b1;
      end
      WR_WAIT: begin
        // a fresh ADS in the same cycle starts a new cycle instead
        if (!bus.cpu_WR_n && !ads_edge) begin
          state_d = IDLE;
          if (addr_q <= ROM_TOP) begin
            wp_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wdata_d = bus.cpu_D_o;
          end
        end
      end
      default: ;
    endcase

    if (ads_edge) begin
      // still pending after rvalid handling means the old read is abandoned
      if (state_d == RD_PEND) drop_d = drop_inc(drop_d);
      addr_d      = {bus.cpu_D_o[3:0], bus.cpu_addr};
      flags_d     = bus.cpu_D_o[7:4];
      rdata_vld_d = 1'b0;
      halt_d      = bus.cpu_D_o[7];
      lat_d       = '0;
      if (bus.cpu_D_o[4]) begin
        rd_d    = 1'b1;
        state_d = RD_PEND;
      end else begin
        state_d = WR_WAIT;
      end
    end
  end

  // State register; everything returns to idle values as soon as rst_n falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ads_n_q     <= 1'b1;
      addr_q      <= '0;
      flags_q     <= '0;
      rd_q        <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      halt_q      <= 1'b0;
      late_q      <= 1'b0;
      wp_q        <= 1'b0;
      drop_q      <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      ads_n_q     <= ads_n_d;
      addr_q      <= addr_d;
      flags_q     <= flags_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      halt_q      <= halt_d;
      late_q      <= late_d;
      wp_q        <= wp_d;
      drop_q      <= drop_d;
      lat_q       <= lat_d;
    end
  end

  assign bus.cpu_D_i   = (rdata_vld_q && !bus.cpu_RD_n) ? rdata_q : IDLE_DATA;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cyc_flags = flags_q;
  assign bus.halt_p    = halt_q;
  assign bus.late_err  = late_q;
  assign bus.wp_err    = wp_q;

endmodule

// File: tb/tb_scmp_bus_if.sv
// Directed table-driven bench for scmp_bus_if plus a hand-written reset sequence.
module tb_scmp_bus_if;

  logic clk;
  logic rst_n;

  scmp_bus_if_if bus();

  scmp_bus_if dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ads_n;
    logic        rd_n;
    logic        wr_n;
    logic [11:0] addr;
    logic [7:0]  d_o;
    logic        rvalid;
    logic [7:0]  rdata;
    logic [7:0]  e_di;
    logic [15:0] e_addr;
    logic        e_rd;
    logic        e_we;
    logic [7:0]  e_wdata;
    logic [3:0]  e_flags;
    logic        e_halt;
    logic        e_late;
    logic        e_wp;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic ads_n, input logic rd_n, input logic wr_n,
                       input logic [11:0] addr, input logic [7:0] d_o,
                       input logic rvalid, input logic [7:0] rdata);
    bus.cpu_ADS_n  = ads_n;
    bus.cpu_RD_n   = rd_n;
    bus.cpu_WR_n   = wr_n;
    bus.cpu_addr   = addr;
    bus.cpu_D_o    = d_o;
    bus.mem_rvalid = rvalid;
    bus.mem_rdata  = rdata;
  endtask

  task automatic check_all(input int idx, input logic [7:0] di, input logic [15:0] addr,
                           input logic rd, input logic we, input logic [7:0] wdata,
                           input logic [3:0] flags, input logic halt, input logic late,
                           input logic wp);
    check("cpu_D_i",   idx, {8'h00, bus.cpu_D_i},   {8'h00, di});
    check("mem_addr",  idx, bus.mem_addr,           addr);
    check("mem_rd",    idx, {15'h0, bus.mem_rd},    {15'h0, rd});
    check("mem_we",    idx, {15'h0, bus.mem_we},    {15'h0, we});
    check("mem_wdata", idx, {8'h00, bus.mem_wdata}, {8'h00, wdata});
    check("cyc_flags", idx, {12'h0, bus.cyc_flags}, {12'h0, flags});
    check("halt_p",    idx, {15'h0, bus.halt_p},    {15'h0, halt});
    check("late_err",  idx, {15'h0, bus.late_err},  {15'h0, late});
    check("wp_err",    idx, {15'h0, bus.wp_err},    {15'h0, wp});
  endtask

  initial begin
    //             ads rd wr addr    d_o   rv rdata  e_di   e_addr    rd we wdata flg hl lt wp
    // read 0x5234, ADS held two cycles, byte 2 cycles after mem_rd
    vecs[0]  = '{1'b0,1'b1,1'b1,12'h234,8'h15,1'b0,8'h00, 8'hFF,16'h5234,1'b1,1'b0,8'h00,4'h1,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b1,12'h777,8'h15,1'b0,8'h00, 8'hFF,16'h5234,1'b0,1'b0,8'h00,4'h1,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h5234,1'b0,1'b0,8'h00,4'h1,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b1,8'hA7, 8'hFF,16'h5234,1'b0,1'b0,8'h00,4'h1,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hA7,16'h5234,1'b0,1'b0,8'h00,4'h1,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h5234,1'b0,1'b0,8'h00,4'h1,1'b0,1'b0,1'b0};
    // write 0x2100 <= 0x3C with WR_n low three cycles
    vecs[6]  = '{1'b0,1'b1,1'b1,12'h100,8'h02,1'b0,8'h00, 8'hFF,16'h2100,1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b1,1'b1,1'b0,12'h100,8'h3C,1'b0,8'h00, 8'hFF,16'h2100,1'b0,1'b1,8'h3C,4'h0,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b1,1'b0,12'h100,8'h3C,1'b0,8'h00, 8'hFF,16'h2100,1'b0,1'b0,8'h3C,4'h0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b0,12'h100,8'h3C,1'b0,8'h00, 8'hFF,16'h2100,1'b0,1'b0,8'h3C,4'h0,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h2100,1'b0,1'b0,8'h3C,4'h0,1'b0,1'b0,1'b0};
    // write into protected region 0x0800
    vecs[11] = '{1'b0,1'b1,1'b1,12'h800,8'h00,1'b0,8'h00, 8'hFF,16'h0800,1'b0,1'b0,8'h3C,4'h0,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b1,1'b0,12'h800,8'h55,1'b0,8'h00, 8'hFF,16'h0800,1'b0,1'b0,8'h3C,4'h0,1'b0,1'b0,1'b1};
    vecs[13] = '{1'b1,1'b1,1'b0,12'h800,8'h55,1'b0,8'h00, 8'hFF,16'h0800,1'b0,1'b0,8'h3C,4'h0,1'b0,1'b0,1'b1};
    vecs[14] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h0800,1'b0,1'b0,8'h3C,4'h0,1'b0,1'b0,1'b1};
    // abort: second read before first rvalid, first byte dropped
    vecs[15] = '{1'b0,1'b1,1'b1,12'h300,8'h11,1'b0,8'h00, 8'hFF,16'h1300,1'b1,1'b0,8'h3C,4'h1,1'b0,1'b0,1'b1};
    vecs[16] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h1300,1'b0,1'b0,8'h3C,4'h1,1'b0,1'b0,1'b1};
    vecs[17] = '{1'b0,1'b1,1'b1,12'h400,8'h11,1'b0,8'h00, 8'hFF,16'h1400,1'b1,1'b0,8'h3C,4'h1,1'b0,1'b0,1'b1};
    vecs[18] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h1400,1'b0,1'b0,8'h3C,4'h1,1'b0,1'b0,1'b1};
    vecs[19] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b1,8'h11, 8'hFF,16'h1400,1'b0,1'b0,8'h3C,4'h1,1'b0,1'b0,1'b1};
    vecs[20] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b1,8'h22, 8'hFF,16'h1400,1'b0,1'b0,8'h3C,4'h1,1'b0,1'b0,1'b1};
    vecs[21] = '{1'b1,1'b0,1'b1,12'h000,8'h00,1'b0,8'h00, 8'h22,16'h1400,1'b0,1'b0,8'h3C,4'h1,1'b0,1'b0,1'b1};
    vecs[22] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h1400,1'b0,1'b0,8'h3C,4'h1,1'b0,1'b0,1'b1};
    // late: RD_n low while read still pending; then halt cycle
    vecs[23] = '{1'b0,1'b1,1'b1,12'h050,8'h10,1'b0,8'h00, 8'hFF,16'h0050,1'b1,1'b0,8'h3C,4'h1,1'b0,1'b0,1'b1};
    vecs[24] = '{1'b1,1'b0,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h0050,1'b0,1'b0,8'h3C,4'h1,1'b0,1'b1,1'b1};
    vecs[25] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h0050,1'b0,1'b0,8'h3C,4'h1,1'b0,1'b1,1'b1};
    vecs[26] = '{1'b0,1'b1,1'b1,12'h000,8'h80,1'b0,8'h00, 8'hFF,16'h0000,1'b0,1'b0,8'h3C,4'h8,1'b1,1'b1,1'b1};
    vecs[27] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h0000,1'b0,1'b0,8'h3C,4'h8,1'b0,1'b1,1'b1};
    vecs[28] = '{1'b1,1'b1,1'b1,12'h000,8'h00,1'b0,8'h00, 8'hFF,16'h0000,1'b0,1'b0,8'h3C,4'h8,1'b0,1'b1,1'b1};

    // reset state
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 12'h000, 8'h00, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_all(-1, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table: drive, clock, compare registered/combinational outputs
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ads_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].addr, vecs[i].d_o,
            vecs[i].rvalid, vecs[i].rdata);
      @(posedge clk);
      #1;
      check_all(i, vecs[i].e_di, vecs[i].e_addr, vecs[i].e_rd, vecs[i].e_we,
                vecs[i].e_wdata, vecs[i].e_flags, vecs[i].e_halt, vecs[i].e_late,
                vecs[i].e_wp);
    end

    // reset while a read is pending, asserted mid-cycle
    drive(1'b0, 1'b1, 1'b1, 12'h0AB, 8'h13, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("rst_seq mem_rd", 100, {15'h0, bus.mem_rd}, 16'h0001);
    check("rst_seq mem_addr", 100, bus.mem_addr, 16'h30AB);
    drive(1'b1, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(101, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all(102, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // stray rvalid with nothing pending must be ignored
    drive(1'b1, 1'b1, 1'b1, 12'h000, 8'h00, 1'b1, 8'h99);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check_all(103, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);

    // after the reset a normal read must complete without being dropped
    drive(1'b0, 1'b1, 1'b1, 12'h456, 8'h1F, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b1, 12'h000, 8'h00, 1'b1, 8'h5A);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 8'h00);
    #1;
    check_all(104, 8'h5A, 16'hF456, 1'b0, 1'b0, 8'h00, 4'h1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 12'h000, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
